// File: rtl/y_cmp_pkg.sv
// Shared constants and state encoding for the y-bus MISR compactor.
package y_cmp_pkg;

    localparam int               SIG_W = 32;
    localparam logic [SIG_W-1:0] POLY  = 32'h04C11DB7;
    localparam logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;

endpackage

// File: rtl/y_fold.sv
// Folds a wide bus into SIG_W bits by XOR-ing its zero-extended SIG_W-bit slices.
module y_fold #(
    parameter int Y_W   = 245,
    parameter int SIG_W = 32
) (
    input  logic [Y_W-1:0]   y_i,
    output logic [SIG_W-1:0] fold_o
);

    localparam int N_SL = (Y_W + SIG_W - 1) / SIG_W;

    logic [N_SL*SIG_W-1:0] y_ext;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        y_ext          = '0;
        y_ext[Y_W-1:0] = y_i;
        fold_o         = '0;
        for (int s = 0; s < N_SL; s++) begin
            fold_o = fold_o ^ y_ext[s*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/y_misr_compactor.sv
// Compacts the y result bus into a MISR signature over a programmed number of
// cycles, then offers it on a valid/ready handshake.
module y_misr_compactor
    import y_cmp_pkg::*;
#(
    parameter int Y_W   = 245,
    parameter int SIG_W = y_cmp_pkg::SIG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Y_W-1:0]   y,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    output logic             busy,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] cycles_done
);

    cmp_state_t       state_q,     state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] cycles_q,    cycles_d;
    logic [SIG_W-1:0] sig_q,       sig_d;
    logic [SIG_W-1:0] fold_y;
    logic [SIG_W-1:0] misr_next;

    y_fold #(
        .Y_W   (Y_W),
        .SIG_W (SIG_W)
    ) u_fold (
        .y_i    (y),
        .fold_o (fold_y)
    );

    // Galois-style shift with feedback from the MSB, then inject the folded sample.
    assign misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ fold_y;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cycles_d    = cycles_q;
        sig_d       = sig_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = num_cycles;
                    cycles_d    = '0;
                    sig_d       = SEED;
                    state_d     = (num_cycles == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                sig_d       = misr_next;
                cycles_d    = cycles_q + CNT_W'(1);
                remaining_d = remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (sig_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cycles_q    <= '0;
            sig_q       <= SEED;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cycles_q    <= cycles_d;
            sig_q       <= sig_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign sig_valid   = (state_q == DONE);
    assign sig         = sig_q;
    assign cycles_done = cycles_q;

endmodule

// File: tb/tb_y_misr_compactor.sv
// Scoreboard bench for y_misr_compactor: expected signatures are queued as y is driven.
module tb_y_misr_compactor;

    localparam logic [31:0] T_POLY = 32'h04C11DB7;
    localparam logic [31:0] T_SEED = 32'hFFFFFFFF;

    typedef struct {
        logic [31:0] sig;
        logic [15:0] cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [244:0] y;
    logic         start;
    logic [15:0]  num_cycles;
    logic         busy;
    logic         sig_valid;
    logic         sig_ready;
    logic [31:0]  sig;
    logic [15:0]  cycles_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    y_misr_compactor dut (
        .clk         (clk),
        .rst         (rst),
        .y           (y),
        .start       (start),
        .num_cycles  (num_cycles),
        .busy        (busy),
        .sig_valid   (sig_valid),
        .sig_ready   (sig_ready),
        .sig         (sig),
        .cycles_done (cycles_done)
    );

    // Bit i of y lands on signature bit i mod 32.
    function automatic logic [31:0] ref_fold(input logic [244:0] v);
        logic [31:0] r = '0;
        for (int i = 0; i < 245; i++) r[i % 32] = r[i % 32] ^ v[i];
        return r;
    endfunction

    function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [244:0] v);
        logic [31:0] t = s << 1;
        if (s[31]) t = t ^ T_POLY;
        return t ^ ref_fold(v);
    endfunction

    function automatic logic [244:0] gen_y(input int mode);
        logic [255:0] w;
        if (mode == 0) return '0;
        if (mode == 1) return 245'h1;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[244:0];
    endfunction

    // One complete run: start, feed n samples, hold off the handshake for `hold` cycles, accept.
    task automatic do_run(input int n, input int mode, input int hold, input bit pulse_start,
                          input bit use_const, input logic [31:0] const_sig);
        logic [31:0]  m;
        logic [244:0] v;
        exp_t         e;
        @(posedge clk); #1;
        start      = 1'b1;
        num_cycles = n[15:0];
        @(posedge clk); #1;
        start      = 1'b0;
        num_cycles = '0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_start n=%0d: got %b want 1", n, busy);
        end
        if (n > 0) begin
            n_checks++;
            if (sig_valid !== 1'b0) begin
                n_fail++; $display("FAIL valid_early n=%0d: got %b want 0", n, sig_valid);
            end
        end
        m = T_SEED;
        for (int i = 0; i < n; i++) begin
            v = gen_y(mode);
            y = v;
            m = ref_step(m, v);
            if (pulse_start && i == 3) begin
                start      = 1'b1;
                num_cycles = 16'd3;
            end
            @(posedge clk); #1;
            start      = 1'b0;
            num_cycles = '0;
        end
        e.sig = use_const ? const_sig : m;
        e.cyc = n[15:0];
        exp_q.push_back(e);
        y = '0;
        n_checks++;
        if (sig_valid !== 1'b1) begin
            n_fail++; $display("FAIL valid_timing n=%0d: got %b want 1", n, sig_valid);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (sig !== e.sig) begin
                n_fail++; $display("FAIL sig n=%0d: got %h want %h", n, sig, e.sig);
            end
            n_checks++;
            if (cycles_done !== e.cyc) begin
                n_fail++; $display("FAIL cycles_done n=%0d: got %0d want %0d", n, cycles_done, e.cyc);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sig_valid !== 1'b1 || sig !== e.sig) begin
                n_fail++;
                $display("FAIL hold_stable cyc=%0d: got valid=%b sig=%h want valid=1 sig=%h",
                         h, sig_valid, sig, e.sig);
            end
        end
        sig_ready = 1'b1;
        @(posedge clk); #1;
        sig_ready = 1'b0;
        n_checks++;
        if (sig_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL handshake_exit: got valid=%b busy=%b want 0 0", sig_valid, busy);
        end
        n_checks++;
        if (sig !== e.sig || cycles_done !== e.cyc) begin
            n_fail++;
            $display("FAIL retained_after_accept: got sig=%h cyc=%0d want sig=%h cyc=%0d",
                     sig, cycles_done, e.sig, e.cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || sig_valid !== 1'b0 || sig !== T_SEED || cycles_done !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b valid=%b sig=%h cyc=%0d want 0 0 ffffffff 0",
                     busy, sig_valid, sig, cycles_done);
        end
    endtask

    task automatic test_zero_cycles();
        do_run(0, 0, 0, 1'b0, 1'b1, T_SEED);
    endtask

    task automatic test_single_samples();
        do_run(1, 0, 0, 1'b0, 1'b1, 32'hFB3EE249);
        do_run(1, 1, 0, 1'b0, 1'b1, 32'hFB3EE248);
    endtask

    task automatic test_backpressure();
        do_run(4, 2, 5, 1'b0, 1'b0, '0);
    endtask

    task automatic test_start_ignored();
        do_run(8, 2, 0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_rst_midrun();
        @(posedge clk); #1;
        start      = 1'b1;
        num_cycles = 16'd10;
        @(posedge clk); #1;
        start      = 1'b0;
        num_cycles = '0;
        for (int i = 0; i < 3; i++) begin
            y = gen_y(2);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        y   = '0;
        n_checks++;
        if (busy !== 1'b0 || sig_valid !== 1'b0 || sig !== T_SEED || cycles_done !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_midrun: got busy=%b valid=%b sig=%h cyc=%0d want 0 0 ffffffff 0",
                     busy, sig_valid, sig, cycles_done);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (sig_valid !== 1'b0) begin
                n_fail++; $display("FAIL no_valid_after_rst cyc=%0d: got %b want 0", i, sig_valid);
            end
        end
        do_run(2, 2, 0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst        = 1'b1;
        y          = '0;
        start      = 1'b0;
        num_cycles = '0;
        sig_ready  = 1'b0;
        test_reset();
        test_zero_cycles();
        test_single_samples();
        test_backpressure();
        test_start_ignored();
        test_rst_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/y_misr_compactor.md
# y_misr_compactor

Downstream consumer of the fuzzed design's wide result bus `y`. It compresses `y` into a 32-bit signature over a programmable number of clock cycles using a multiple-input signature register (MISR). It then offers the signature through a valid/ready handshake. This lets the identity and synthesised netlists be compared with one word per run instead of strobing 245 bits every cycle.

## Interface
- `Y_W`, 245, width of the `y` bus being compacted (bits `Y_W-1:0`)
- `SIG_W`, 32, signature width
- `CNT_W`, 16, width of the cycle-count operand
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `y`  in  Y_W  result bus from `top`, sampled once per cycle while running
- `start`  in  1  begin a compaction run; sampled only in IDLE
- `num_cycles`  in  CNT_W  number of `y` samples to fold; latched with `start`
- `busy`  out  1  high in RUN and DONE
- `sig_valid`  out  1  signature available
- `sig_ready`  in  1  consumer accepts signature
- `sig`  out  SIG_W  current MISR contents
- `cycles_done`  out  CNT_W  samples folded so far in the current run

## Operation
- One clock, `clk`; reset `rst` is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 latches `num_cycles` into `remaining`, loads `sig` with SEED, and clears `cycles_done`.
  - Goes to RUN if `num_cycles`≠0. Goes directly to DONE if `num_cycles`=0, in which case `sig`=SEED.
- **RUN**
  - Each cycle: `sig` ← MISR(`sig`, fold(`y`)), `cycles_done`+1, `remaining`−1.
  - When `remaining`=1 the current cycle is the last fold, and the next state is DONE.
- **DONE**
  - `sig_valid`=1 and `sig` is held stable.
  - `sig_valid && sig_ready` returns the FSM to IDLE. `sig` and `cycles_done` keep their values until the next `start`.
- **fold(`y`):** zero-extend `y` to 256 bits, then XOR its eight 32-bit slices (slice 0 = bits 31:0).
- **MISR step:** next = {`sig`[30:0],1'b0} ^ (`sig`[31] ? POLY : 0) ^ fold(`y`). POLY = 32'h04C11DB7, SEED = 32'hFFFFFFFF.
- `start` is ignored in RUN and DONE.
- `sig_ready` is ignored outside DONE.
- `y` is not sampled outside RUN.
- X on `y` during RUN propagates into `sig`; this is intended, so the bench sees it.

## Timing
- Reset values: state IDLE, `busy`=0, `sig_valid`=0, `sig`=32'hFFFFFFFF, `cycles_done`=0.
- `start` at edge k:
  - `busy`=1 from k+1.
  - The first `y` sample is taken at edge k+1.
  - The last sample is taken at edge k+N.
  - `sig_valid`=1 from k+N+1.
  - Total latency from `start` to valid is N+1 cycles.
- N=0: `sig_valid`=1 at k+1.
- Handshake completing at edge m: `sig_valid`=0 and `busy`=0 from m+1. The earliest new `start` is accepted at edge m+1.
- `rst` asserted in any state takes effect at the next edge: the run is abandoned, all outputs return to reset values, and no signature is emitted.
- `cycles_done` saturates only by construction, since it never exceeds `num_cycles`.

## Structure
- Package `y_cmp_pkg`:
  - constants `SIG_W`, `POLY`, `SEED`
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t`
- Sub-module `y_fold`: purely combinational, parameterised on `Y_W`/`SIG_W`, producing fold(`y`). The top holds the FSM, counters and MISR register.

## Test plan
- Reset, then `start` with N=0 → `sig_valid` at the next cycle, `sig`=32'hFFFFFFFF, `cycles_done`=0.
- `y`=0, N=1 → `sig`=32'hFB3EE249 after 2 cycles, `cycles_done`=1.
- `y`=245'h1 held, N=1 → `sig`=32'hFB3EE248 (fold contributes bit 0 only).
- N=4 with `sig_ready` held low for 5 cycles after valid → `sig` and `sig_valid` stable throughout; `busy` drops the cycle after `sig_ready` rises.
- `start` pulsed again during RUN (N=8) → ignored; `cycles_done` ends at 8, and the signature matches the reference model fed the 8 sampled `y` values.
- `rst` at RUN cycle 3 of N=10 → next cycle IDLE, `sig`=32'hFFFFFFFF, `sig_valid` never asserts; a following run with N=2 completes normally.
